// File: rtl/memory_port_arbiter.sv
// memory_port_arbiter: shares one single-ported memory bus between fetch and the Memory stage.
// Ports: clock/reset; fetch request/kill/response; load/store request/response; mem* bus handshake.
module memory_port_arbiter (
    input  logic        clock,
    input  logic        reset,
    input  logic        fetchRequest,
    input  logic [31:0] fetchAddress,
    input  logic        fetchKill,
    output logic [31:0] fetchData,
    output logic        fetchDataValid,
    input  logic        loadRequest,
    input  logic        storeRequest,
    input  logic [31:0] dataAddress,
    input  logic [31:0] storeData,
    input  logic [3:0]  storeByteEnable,
    output logic [31:0] loadData,
    output logic        loadDataValid,
    output logic        storeComplete,
    output logic        memRequest,
    output logic        memWriteEnable,
    output logic [31:0] memAddress,
    output logic [31:0] memWriteData,
    output logic [3:0]  memByteEnable,
    input  logic        memAcknowledge,
    input  logic [31:0] memReadData
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESPOND
    } state_t;

    typedef enum logic {
        FETCH,
        DATA
    } requester_t;

    state_t     state;
    requester_t owner;
    requester_t lastGrant;
    logic       killed;
    logic       fetchPulse;

    logic dataPending;
    logic grantFetch;
    logic grantData;

    assign dataPending = loadRequest | storeRequest;

    // Round robin on a tie: the side that did not win last time goes next.
    assign grantFetch = fetchRequest & (~dataPending | (lastGrant == DATA));
    assign grantData  = dataPending & ~grantFetch;

    // A redirect arriving in the response cycle still has to hide the pulse.
    assign fetchDataValid = fetchPulse & ~fetchKill;

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= IDLE;
            owner          <= FETCH;
            lastGrant      <= DATA;
            killed         <= 1'b0;
            fetchPulse     <= 1'b0;
            loadDataValid  <= 1'b0;
            storeComplete  <= 1'b0;
            fetchData      <= 32'd0;
            loadData       <= 32'd0;
            memRequest     <= 1'b0;
            memWriteEnable <= 1'b0;
            memAddress     <= 32'd0;
            memWriteData   <= 32'd0;
            memByteEnable  <= 4'd0;
        end else begin
            fetchPulse    <= 1'b0;
            loadDataValid <= 1'b0;
            storeComplete <= 1'b0;
            unique case (state)
                IDLE: begin
                    killed <= 1'b0;
                    if (grantFetch) begin
                        owner          <= FETCH;
                        lastGrant      <= FETCH;
                        memRequest     <= 1'b1;
                        memWriteEnable <= 1'b0;
                        memAddress     <= fetchAddress;
                        memWriteData   <= 32'd0;
                        memByteEnable  <= 4'b1111;
                        state          <= BUSY;
                    end else if (grantData) begin
                        // Store wins over a simultaneous load.
                        owner          <= DATA;
                        lastGrant      <= DATA;
                        memRequest     <= 1'b1;
                        memWriteEnable <= storeRequest;
                        memAddress     <= dataAddress;
                        memWriteData   <= storeRequest ? storeData : 32'd0;
                        memByteEnable  <= storeRequest ? storeByteEnable
                                                       : 4'b1111;
                        state          <= BUSY;
                    end
                end
                BUSY: begin
                    if (owner == FETCH && fetchKill) begin
                        killed <= 1'b1;
                    end
                    if (memAcknowledge) begin
                        memRequest <= 1'b0;
                        state      <= RESPOND;
                        if (owner == FETCH) begin
                            fetchData  <= memReadData;
                            fetchPulse <= ~(killed | fetchKill);
                        end else if (memWriteEnable) begin
                            storeComplete <= 1'b1;
                        end else begin
                            loadData      <= memReadData;
                            loadDataValid <= 1'b1;
                        end
                    end
                end
                RESPOND: begin
                    // No grant here, so a requester can drop its level.
                    killed <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    no_load_and_store: assert property (
        @(posedge clock) disable iff (reset)
        !(state == IDLE && loadRequest && storeRequest)
    );

endmodule
